muldiv_ctrl: RTL



---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_ctrl_div_step.sv | 29 ++
 rtl/muldiv_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_RUN  = 2'd2,
        ST_DIV_FIX  = 2'd3
    } state_t;

    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_DIV    = 1'b1;
    localparam int   DIV_ITERS = 32;
    localparam int   CNT_W     = 5;

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvsr_ext;
    logic             ge;

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        dvsr_ext = {2'b00, divisor};
        ge       = shifted >= dvsr_ext;
        if (ge) begin
            rem_next = (WIDTH+1)'(shifted - dvsr_ext);
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: drives an external multiplier over a fixed window
// and runs a signed restoring divider one bit per cycle.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH:0]     rem, rem_n, step_rem;
    logic [WIDTH-1:0]   quo, quo_n, step_quo;
    logic [WIDTH-1:0]   dvsr, dvsr_n;
    logic               sign_q, sign_q_n;
    logic               sign_r, sign_r_n;
    logic [WIDTH-1:0]   mul_a_n, mul_b_n, hi_n, lo_n;
    logic               busy_n, done_n, dz_n;
    logic [WIDTH-1:0]   a_abs, b_abs;

    assign a_abs = a[WIDTH-1] ? -a : a;
    assign b_abs = b[WIDTH-1] ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        quo_n    = quo;
        dvsr_n   = dvsr;
        sign_q_n = sign_q;
        sign_r_n = sign_r;
        mul_a_n  = mul_a;
        mul_b_n  = mul_b;
        hi_n     = hi;
        lo_n     = lo;
        busy_n   = busy;
        done_n   = 1'b0;
        dz_n     = div_zero;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    dz_n = 1'b0;
                    if (op_div == OP_DIV) begin
                        if (b == '0) begin
                            // Divide by zero resolves immediately, never busy
                            hi_n   = a;
                            lo_n   = '1;
                            dz_n   = 1'b1;
                            done_n = 1'b1;
                        end else begin
                            quo_n    = a_abs;
                            dvsr_n   = b_abs;
                            rem_n    = '0;
                            sign_q_n = a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r_n = a[WIDTH-1];
                            cnt_n    = CNT_W'(DIV_ITERS - 1);
                            busy_n   = 1'b1;
                            state_n  = ST_DIV_RUN;
                        end
                    end else begin
                        mul_a_n = a;
                        mul_b_n = b;
                        cnt_n   = CNT_W'(MUL_LAT - 1);
                        busy_n  = 1'b1;
                        state_n = ST_MUL_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (cnt == '0) begin
                    hi_n    = mul_hi;
                    lo_n    = mul_lo;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DIV_RUN: begin
                rem_n = step_rem;
                quo_n = step_quo;
                if (cnt == '0) begin
                    state_n = ST_DIV_FIX;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DIV_FIX: begin
                lo_n    = sign_q ? -quo : quo;
                hi_n    = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            quo      <= quo_n;
            dvsr     <= dvsr_n;
            sign_q   <= sign_q_n;
            sign_r   <= sign_r_n;
            mul_a    <= mul_a_n;
            mul_b    <= mul_b_n;
            hi       <= hi_n;
            lo       <= lo_n;
            busy     <= busy_n;
            done     <= done_n;
            div_zero <= dz_n;
        end
    end

endmodule
